// File: rtl/sid_regs.sv
// -----------------------------------------------------------------------------
// sid_regs -- SID-style register file behind an SPI front end.
//
// Holds the three voice register banks (frequency, pulse width, control,
// attack/decay, sustain/release) plus the filter/volume registers. It drives
// every configuration field straight from its storage flops, and it serves a
// registered read port. It also emits one-cycle gate rise/fall pulses per voice.
//
// Ports:
//   clk_i        system clock
//   rst_i        synchronous active-high reset
//   reg_addr_i   7-bit register address
//   reg_wdata_i  write data
//   reg_we_i     write enable (may be held high; repeated writes are harmless)
//   reg_rdata_o  registered read data for the address sampled at the last edge
//   osc3_i       voice 3 oscillator upper byte, readable at 0x1B
//   env3_i       voice 3 envelope value, readable at 0x1C
//   freq_o       voice n frequency at [16n+15:16n]
//   pw_o         voice n pulse width at [12n+11:12n]
//   ctrl_o       voice n control byte at [8n+7:8n]
//   ad_o         voice n attack/decay byte
//   sr_o         voice n sustain/release byte
//   fc_o         filter cutoff {FC_HI, FC_LO[2:0]}
//   res_filt_o   resonance / filter routing
//   mode_vol_o   filter mode / volume
//   gate_rise_o  one-cycle pulse per voice when gate goes 0->1
//   gate_fall_o  one-cycle pulse per voice when gate goes 1->0
// -----------------------------------------------------------------------------
module sid_regs #(
  parameter int NUM_VOICES = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [6:0]                reg_addr_i,
  input  logic [7:0]                reg_wdata_i,
  input  logic                      reg_we_i,
  output logic [7:0]                reg_rdata_o,
  input  logic [7:0]                osc3_i,
  input  logic [7:0]                env3_i,
  output logic [16*NUM_VOICES-1:0]  freq_o,
  output logic [12*NUM_VOICES-1:0]  pw_o,
  output logic [8*NUM_VOICES-1:0]   ctrl_o,
  output logic [8*NUM_VOICES-1:0]   ad_o,
  output logic [8*NUM_VOICES-1:0]   sr_o,
  output logic [10:0]               fc_o,
  output logic [7:0]                res_filt_o,
  output logic [7:0]                mode_vol_o,
  output logic [NUM_VOICES-1:0]     gate_rise_o,
  output logic [NUM_VOICES-1:0]     gate_fall_o
);

  logic [7:0]            w_vdata [NUM_VOICES];
  logic [NUM_VOICES-1:0] w_gate;
  logic [7:0]            w_rdata;

  logic [2:0]            r_fc_lo;
  logic [7:0]            r_fc_hi;
  logic [7:0]            r_res_filt;
  logic [7:0]            r_mode_vol;
  logic [7:0]            r_rdata;
  logic [NUM_VOICES-1:0] r_gate_prev;
  logic [NUM_VOICES-1:0] r_gate_rise;
  logic [NUM_VOICES-1:0] r_gate_fall;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
      localparam logic [6:0] BASE = 7'(7 * gi);

      logic [7:0] r_freq_lo;
      logic [7:0] r_freq_hi;
      logic [7:0] r_pw_lo;
      logic [3:0] r_pw_hi;
      logic [7:0] r_ctrl;
      logic [7:0] r_ad;
      logic [7:0] r_sr;
      logic [7:0] w_rd;

      // Byte-wide registers, no shadowing: a LO write is visible immediately.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          r_freq_lo <= 8'h00;
          r_freq_hi <= 8'h00;
          r_pw_lo   <= 8'h00;
          r_pw_hi   <= 4'h0;
          r_ctrl    <= 8'h00;
          r_ad      <= 8'h00;
          r_sr      <= 8'h00;
        end else if (reg_we_i) begin
          case (reg_addr_i)
            BASE:         r_freq_lo <= reg_wdata_i;
            BASE + 7'd1:  r_freq_hi <= reg_wdata_i;
            BASE + 7'd2:  r_pw_lo   <= reg_wdata_i;
            BASE + 7'd3:  r_pw_hi   <= reg_wdata_i[3:0];
            BASE + 7'd4:  r_ctrl    <= reg_wdata_i;
            BASE + 7'd5:  r_ad      <= reg_wdata_i;
            BASE + 7'd6:  r_sr      <= reg_wdata_i;
            default: ;
          endcase
        end
      end

      // Read contribution of this voice; zero when the address is not ours,
      // so the voices can simply be OR-ed together.
      always_comb begin
        w_rd = 8'h00;
        case (reg_addr_i)
          BASE:         w_rd = r_freq_lo;
          BASE + 7'd1:  w_rd = r_freq_hi;
          BASE + 7'd2:  w_rd = r_pw_lo;
          BASE + 7'd3:  w_rd = {4'h0, r_pw_hi};
          BASE + 7'd4:  w_rd = r_ctrl;
          BASE + 7'd5:  w_rd = r_ad;
          BASE + 7'd6:  w_rd = r_sr;
          default:      w_rd = 8'h00;
        endcase
      end

      assign w_vdata[gi]          = w_rd;
      assign w_gate[gi]           = r_ctrl[0];
      assign freq_o[16*gi +: 16]  = {r_freq_hi, r_freq_lo};
      assign pw_o[12*gi +: 12]    = {r_pw_hi, r_pw_lo};
      assign ctrl_o[8*gi +: 8]    = r_ctrl;
      assign ad_o[8*gi +: 8]      = r_ad;
      assign sr_o[8*gi +: 8]      = r_sr;
    end
  endgenerate

  // Filter / volume registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_fc_lo    <= 3'h0;
      r_fc_hi    <= 8'h00;
      r_res_filt <= 8'h00;
      r_mode_vol <= 8'h00;
    end else if (reg_we_i) begin
      case (reg_addr_i)
        7'h15:   r_fc_lo    <= reg_wdata_i[2:0];
        7'h16:   r_fc_hi    <= reg_wdata_i;
        7'h17:   r_res_filt <= reg_wdata_i;
        7'h18:   r_mode_vol <= reg_wdata_i;
        default: ;
      endcase
    end
  end

  // Read mux. It reads the storage before this edge's write lands, so a
  // same-cycle read/write of one address returns the old value.
  always_comb begin
    w_rdata = 8'h00;
    for (int n = 0; n < NUM_VOICES; n++) begin
      w_rdata = w_rdata | w_vdata[n];
    end
    case (reg_addr_i)
      7'h15:   w_rdata = {5'h00, r_fc_lo};
      7'h16:   w_rdata = r_fc_hi;
      7'h17:   w_rdata = r_res_filt;
      7'h18:   w_rdata = r_mode_vol;
      7'h1B:   w_rdata = osc3_i;
      7'h1C:   w_rdata = env3_i;
      default: ;
    endcase
  end

  // Gate edge detect against the gate value one cycle earlier. A CTRL write
  // committed at edge k therefore pulses after edge k+1. Consecutive toggles
  // give consecutive pulses, and a write right after reset can only pulse
  // on the following cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rdata     <= 8'h00;
      r_gate_prev <= '0;
      r_gate_rise <= '0;
      r_gate_fall <= '0;
    end else begin
      r_rdata     <= w_rdata;
      r_gate_prev <= w_gate;
      r_gate_rise <= w_gate & ~r_gate_prev;
      r_gate_fall <= ~w_gate & r_gate_prev;
    end
  end

  assign reg_rdata_o = r_rdata;
  assign fc_o        = {r_fc_hi, r_fc_lo};
  assign res_filt_o  = r_res_filt;
  assign mode_vol_o  = r_mode_vol;
  assign gate_rise_o = r_gate_rise;
  assign gate_fall_o = r_gate_fall;

endmodule

// File: doc/sid_regs.md
SID_REGS -- requirements
Module: sid_regs

Interface
REQ-001 The block SHALL have one clock `clk_i` and one reset `rst_i`; the reset is synchronous and active-high.
REQ-002 The block SHALL have the following ports, one per line as name, direction, width, meaning:
- clk_i  in  1  system clock (50 MHz)
- rst_i  in  1  synchronous active-high reset
- reg_addr_i  in  7  register address from SPI front end
- reg_wdata_i  in  8  write data
- reg_we_i  in  1  write enable, may stay high for several cycles
- reg_rdata_o  out  8  registered read data
- osc3_i  in  8  voice 3 oscillator upper byte (read-only source)
- env3_i  in  8  voice 3 envelope value (read-only source)
- freq_o  out  48  voice n frequency at [16n+15:16n], n = 0..2
- pw_o  out  36  voice n pulse width at [12n+11:12n]
- ctrl_o  out  24  voice n control byte at [8n+7:8n]
- ad_o  out  24  voice n attack/decay byte
- sr_o  out  24  voice n sustain/release byte
- fc_o  out  11  filter cutoff, {FC_HI, FC_LO[2:0]}
- res_filt_o  out  8  resonance / filter routing
- mode_vol_o  out  8  filter mode / volume
- gate_rise_o  out  3  one-cycle pulse, gate bit 0->1 per voice
- gate_fall_o  out  3  one-cycle pulse, gate bit 1->0 per voice

REQ-003 There SHALL be one parameter, NUM_VOICES, default 3, meaning the number of voices; only the value 3 is supported.

Function
REQ-004 The address map SHALL be as follows. Voice n register base = 7*n, for n = 0..2:
- base+0: FREQ_LO
- base+1: FREQ_HI
- base+2: PW_LO
- base+3: PW_HI (bits [3:0] only)
- base+4: CTRL
- base+5: AD
- base+6: SR
- 0x15: FC_LO (bits [2:0] only)
- 0x16: FC_HI
- 0x17: RES_FILT
- 0x18: MODE_VOL
REQ-005 Reads of the following addresses SHALL return:
- 0x19 and 0x1A: 0x00 (POT, not implemented)
- 0x1B: osc3_i
- 0x1C: env3_i
- 0x1D to 0x7F: 0x00
REQ-006 A write SHALL commit at each rising clk_i edge where reg_we_i=1 and reg_addr_i <= 0x18. Repeated cycles with the same address and data are idempotent.
REQ-007 Writes to 0x19 to 0x7F SHALL be ignored with no state change.
REQ-008 Unimplemented bits (PW_HI[7:4], FC_LO[7:3]) SHALL be stored as 0 and read back as 0.
REQ-009 All writable registers SHALL be readable and return their stored, masked value.
REQ-010 reg_rdata_o SHALL be registered. It reflects reg_addr_i sampled at edge k and is valid after edge k.
REQ-011 On a simultaneous read and write to the same address, reg_rdata_o SHALL return the old value; the new value is visible from the next cycle.
REQ-012 Configuration outputs (freq_o through mode_vol_o) SHALL be driven directly from the storage flops. They update at the same edge the write commits, with no extra latency.
REQ-013 16-bit and 12-bit fields SHALL update byte-wise with no shadowing. A LO write followed by a HI write produces an intermediate value for one or more cycles.
REQ-014 gate_rise_o[n] SHALL pulse high for exactly one cycle, on the cycle after a committed CTRL write for voice n where the old bit 0 = 0 and the new bit 0 = 1.
REQ-015 gate_fall_o[n] SHALL pulse high for exactly one cycle under the same rules as REQ-014, for old bit 0 = 1 and new bit 0 = 0.
REQ-016 A write that leaves the gate bit unchanged SHALL produce no pulse, including reg_we_i held high across many cycles.
REQ-017 Back-to-back CTRL writes that toggle the gate on consecutive cycles SHALL produce consecutive rise and fall pulses, none merged or dropped.
REQ-018 osc3_i and env3_i SHALL be sampled only through the reg_rdata_o register and never stored elsewhere.

Reset
REQ-019 While rst_i=1 at a clock edge, all storage, reg_rdata_o, gate_rise_o and gate_fall_o SHALL become 0.
REQ-020 Reset SHALL take priority over a simultaneous write; the write is discarded.
REQ-021 The first cycle after reset release SHALL produce no gate pulse, even if the first write sets the gate. That write pulses one cycle later, per REQ-014.

Verification
REQ-022 A bench SHALL cover the following directed scenarios:
- Reset, then read all addresses 0x00 to 0x7F with osc3_i=0xA5 and env3_i=0x3C: 0x1B returns 0xA5, 0x1C returns 0x3C, all others return 0x00.
- Write 0x00=0x34, then 0x01=0x12: freq_o[15:0] reads 0x0034 and then 0x1234, each at its commit edge; a readback of 0x01 returns 0x12.
- Write 0x0A=0xFF (voice 1 PW_HI): pw_o[23:20]=0xF; readback of 0x0A returns 0x0F. Write 0x15=0xFF: fc_o[2:0]=0x7.
- Write 0x04=0x41 from reset: gate_rise_o=3'b001 for one cycle. Then write 0x04=0x41 with reg_we_i held 5 cycles: no pulse. Then write 0x04=0x40: gate_fall_o=3'b001 for one cycle. Repeat on 0x12 and check bit 2.
- Write 0x1B=0x55 and 0x45=0xAA: no output changes; reads unchanged.
- Assert rst_i in the same cycle as a write of 0x18=0x0F: mode_vol_o stays 0x00. After release, the same write gives mode_vol_o=0x0F.
